id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline boundary between instruction decode and execute. Latches the decoded control bundle, register operands, immediate and PC into the EX stage, and detects load-use hazards against the instruction currently in EX. On a hazard it stalls fetch/decode for one cycle and injects a bubble. Also handles branch flush and downstream back-pressure.

## Interface
Parameters:
- `XLEN`, 64, datapath width (operands, immediate, PC)
- `REG_ADDR_W`, 5, register index width

Ports:
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `idValid`  in  1  ID holds a supported instruction (LD/SD/BEQ/R-format only)
- `branch`, `memRead`, `memToReg`, `memWrite`, `aluSrc`, `regWrite`, `regDst`  in  1 each  decoder control bits
- `aluOp`  in  2  decoder ALU class
- `funct`  in  4  {funct7[5], funct3}
- `rs1`, `rs2`, `rd`  in  REG_ADDR_W  register indices
- `readData1`, `readData2`, `imm`, `pcId`  in  XLEN  register-file data, sign-extended immediate, ID PC
- `flush`  in  1  taken branch resolved downstream; kill ID and EX contents
- `exStall`  in  1  EX cannot accept; hold ID/EX
- `stallIfId`  out  1  hold PC and IF/ID register (combinational)
- `exValid`  out  1  EX slot holds a real instruction
- `exBranch`, `exMemRead`, `exMemToReg`, `exMemWrite`, `exAluSrc`, `exRegWrite`, `exRegDst`  out  1 each
- `exAluOp`  out  2
- `exFunct`  out  4
- `exRs1`, `exRs2`, `exRd`  out  REG_ADDR_W
- `exReadData1`, `exReadData2`, `exImm`, `exPc`  out  XLEN
- `stallCycles`, `bubbleCount`, `flushCount`  out  32  performance counters

## Operation
- `usesRs2 = !aluSrc | memWrite`. rs1 is always used by the four supported opcodes.
- Load-use hazard: `hazard = exValid & exMemRead & exRegWrite & (exRd != 0) & idValid & ((exRd == rs1) | (usesRs2 & (exRd == rs2)))`.
- `stallIfId = !flush & (hazard | exStall)`.
- Register update priority, evaluated per clock:
  1. `reset`: all outputs return to reset values.
  2. `flush`: bubble.
  3. `exStall`: hold all ex* registers.
  4. `hazard`: bubble.
  5. Otherwise load: `exValid <= idValid` and all fields capture their inputs.
- Bubble: `exValid = 0` and all ex* control bits = 0. Data and index fields are don't-care but are driven to 0.
- Load with `idValid = 0`: control bits are captured as 0.
- X sanitising on load: when `regWrite = 0`, `exMemToReg` and `exRegDst` are captured as 0.
- Counters, saturating at 0xFFFFFFFF:
  - `stallCycles` += 1 each cycle `stallIfId = 1`
  - `bubbleCount` += 1 each hazard bubble
  - `flushCount` += 1 each cycle `flush = 1`

## Timing
- Reset values: every `ex*` output is 0, `exValid` is 0, and all counters are 0. `stallIfId` follows its equation, so it is 0 when `exValid = 0` and `flush`/`exStall` are low.
- Latency: ID to EX is 1 cycle.
- A load-use stall lasts exactly one cycle. The bubble clears `exValid`, so `hazard` drops the next cycle and the held ID instruction loads.
- `flush` together with `hazard` or `exStall`: flush wins. Bubble is inserted, `stallIfId = 0`, and `bubbleCount` is not incremented.
- `exStall` together with `hazard`: hold takes priority. `stallIfId = 1`, no bubble, `bubbleCount` unchanged. The hazard is re-evaluated once `exStall` drops.
- `exRd = 0` never causes a hazard.
- A store following a load whose `rd` equals the store's `rs2` is detected (`usesRs2` through `memWrite`).
- `reset` asserted mid-stall: next cycle all outputs are at reset values and the ID instruction is not lost, because IF/ID is held by `stallIfId` and is not owned here.

## Configuration
- `ID_EX_PERF_CNT_EN` defined: the three counters are implemented as above.
- Not defined: no counter flops; `stallCycles`, `bubbleCount` and `flushCount` are tied to 0. Ports are present in both builds.

## Test plan
- Reset, then LD x5 (rd=5, memRead=1, regWrite=1) followed by R-format with rs1=5 -> `stallIfId = 1` for exactly 1 cycle; EX sees `exValid = 0` with all control 0; the R-format enters EX the following cycle; `bubbleCount = 1`.
- LD x5 followed by SD with rs2=5 (aluSrc=1, memWrite=1) -> hazard detected, one bubble. LD x0 followed by R-format with rs1=0 -> no stall.
- LD x5 followed by an LD that uses only rs1=6 with rs2 field=5 -> no stall (`usesRs2 = 0`).
- `flush` asserted during a load-use hazard -> next cycle `exValid = 0`, `stallIfId = 0` in the flush cycle, `flushCount = 1`, `bubbleCount = 0`.
- `exStall` held 3 cycles with an R-format in EX -> ex* outputs unchanged for 3 cycles, `stallIfId = 1`, `stallCycles = 3`. The next ID instruction loads in the cycle after `exStall` falls.
- SD loaded with `memToReg = x` and `regDst = x` -> `exMemToReg = 0` and `exRegDst = 0`. Counters read 0 in a build without `ID_EX_PERF_CNT_EN`.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush and hold.
// Optional perf counters are built only when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  idValid,
    input  logic                  branch,
    input  logic                  memRead,
    input  logic                  memToReg,
    input  logic                  memWrite,
    input  logic                  aluSrc,
    input  logic                  regWrite,
    input  logic                  regDst,
    input  logic [1:0]            aluOp,
    input  logic [3:0]            funct,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [XLEN-1:0]       readData1,
    input  logic [XLEN-1:0]       readData2,
    input  logic [XLEN-1:0]       imm,
    input  logic [XLEN-1:0]       pcId,
    input  logic                  flush,
    input  logic                  exStall,
    output logic                  stallIfId,
    output logic                  exValid,
    output logic                  exBranch,
    output logic                  exMemRead,
    output logic                  exMemToReg,
    output logic                  exMemWrite,
    output logic                  exAluSrc,
    output logic                  exRegWrite,
    output logic                  exRegDst,
    output logic [1:0]            exAluOp,
    output logic [3:0]            exFunct,
    output logic [REG_ADDR_W-1:0] exRs1,
    output logic [REG_ADDR_W-1:0] exRs2,
    output logic [REG_ADDR_W-1:0] exRd,
    output logic [XLEN-1:0]       exReadData1,
    output logic [XLEN-1:0]       exReadData2,
    output logic [XLEN-1:0]       exImm,
    output logic [XLEN-1:0]       exPc,
    output logic [31:0]           stallCycles,
    output logic [31:0]           bubbleCount,
    output logic [31:0]           flushCount
);

    typedef struct packed {
        logic       branch;
        logic       memRead;
        logic       memToReg;
        logic       memWrite;
        logic       aluSrc;
        logic       regWrite;
        logic       regDst;
        logic [1:0] aluOp;
        logic [3:0] funct;
    } ctrl_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       rdata1;
        logic [XLEN-1:0]       rdata2;
        logic [XLEN-1:0]       imm;
        logic [XLEN-1:0]       pc;
    } data_t;

    logic  valid_q, valid_d;
    ctrl_t ctrl_q, ctrl_d;
    data_t data_q, data_d;
    ctrl_t ctrl_in;
    data_t data_in;

    logic uses_rs2;
    logic rs1_match;
    logic rs2_match;
    logic hazard;
    logic do_bubble;
    logic do_hold;

    assign uses_rs2  = !aluSrc | memWrite;
    assign rs1_match = (ctrl_q.memRead ? data_q.rd : '0) == rs1;
    assign rs2_match = uses_rs2 & (data_q.rd == rs2);

    assign hazard = valid_q
                  & ctrl_q.memRead
                  & ctrl_q.regWrite
                  & (data_q.rd != '0)
                  & idValid
                  & ((data_q.rd == rs1) | rs2_match);

    assign stallIfId = !flush & (hazard | exStall);
    assign do_bubble = flush | (!exStall & hazard);
    assign do_hold   = !flush & exStall;

    // Invalid slots carry no control; memToReg/regDst mean nothing without a write.
    always_comb begin
        ctrl_in          = '0;
        if (idValid) begin
            ctrl_in.branch   = branch;
            ctrl_in.memRead  = memRead;
            ctrl_in.memToReg = memToReg & regWrite;
            ctrl_in.memWrite = memWrite;
            ctrl_in.aluSrc   = aluSrc;
            ctrl_in.regWrite = regWrite;
            ctrl_in.regDst   = regDst & regWrite;
            ctrl_in.aluOp    = aluOp;
            ctrl_in.funct    = funct;
        end
    end

    always_comb begin
        data_in.rs1    = rs1;
        data_in.rs2    = rs2;
        data_in.rd     = rd;
        data_in.rdata1 = readData1;
        data_in.rdata2 = readData2;
        data_in.imm    = imm;
        data_in.pc     = pcId;
    end

    always_comb begin
        valid_d = idValid;
        ctrl_d  = ctrl_in;
        data_d  = data_in;
        if (do_bubble) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            data_d  = '0;
        end else if (do_hold) begin
            valid_d = valid_q;
            ctrl_d  = ctrl_q;
            data_d  = data_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign exValid     = valid_q;
    assign exBranch    = ctrl_q.branch;
    assign exMemRead   = ctrl_q.memRead;
    assign exMemToReg  = ctrl_q.memToReg;
    assign exMemWrite  = ctrl_q.memWrite;
    assign exAluSrc    = ctrl_q.aluSrc;
    assign exRegWrite  = ctrl_q.regWrite;
    assign exRegDst    = ctrl_q.regDst;
    assign exAluOp     = ctrl_q.aluOp;
    assign exFunct     = ctrl_q.funct;
    assign exRs1       = data_q.rs1;
    assign exRs2       = data_q.rs2;
    assign exRd        = data_q.rd;
    assign exReadData1 = data_q.rdata1;
    assign exReadData2 = data_q.rdata2;
    assign exImm       = data_q.imm;
    assign exPc        = data_q.pc;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic        hazard_bubble;

    // A flush-induced bubble is not a hazard bubble.
    assign hazard_bubble = !flush & !exStall & hazard;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (stallIfId && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (hazard_bubble && bubble_cnt_q != '1) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
        if (flush && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign stallCycles = stall_cnt_q;
    assign bubbleCount = bubble_cnt_q;
    assign flushCount  = flush_cnt_q;
`else
    assign stallCycles = '0;
    assign bubbleCount = '0;
    assign flushCount  = '0;
`endif

    logic unused_ok;
    assign unused_ok = rs1_match;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: hazards, flush, hold, sanitising, counters.
module tb_id_ex_stage;

`ifdef ID_EX_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        idValid;
    logic        branch, memRead, memToReg, memWrite;
    logic        aluSrc, regWrite, regDst;
    logic [1:0]  aluOp;
    logic [3:0]  funct;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] readData1, readData2, imm, pcId;
    logic        flush, exStall;
    logic        stallIfId, exValid;
    logic        exBranch, exMemRead, exMemToReg, exMemWrite;
    logic        exAluSrc, exRegWrite, exRegDst;
    logic [1:0]  exAluOp;
    logic [3:0]  exFunct;
    logic [4:0]  exRs1, exRs2, exRd;
    logic [63:0] exReadData1, exReadData2, exImm, exPc;
    logic [31:0] stallCycles, bubbleCount, flushCount;

    int asserts = 0;
    int fails   = 0;

    id_ex_stage #(.XLEN(64), .REG_ADDR_W(5)) dut (
        .clock(clock), .reset(reset), .idValid(idValid),
        .branch(branch), .memRead(memRead), .memToReg(memToReg),
        .memWrite(memWrite), .aluSrc(aluSrc), .regWrite(regWrite),
        .regDst(regDst), .aluOp(aluOp), .funct(funct),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .readData1(readData1), .readData2(readData2),
        .imm(imm), .pcId(pcId), .flush(flush), .exStall(exStall),
        .stallIfId(stallIfId), .exValid(exValid), .exBranch(exBranch),
        .exMemRead(exMemRead), .exMemToReg(exMemToReg),
        .exMemWrite(exMemWrite), .exAluSrc(exAluSrc),
        .exRegWrite(exRegWrite), .exRegDst(exRegDst),
        .exAluOp(exAluOp), .exFunct(exFunct),
        .exRs1(exRs1), .exRs2(exRs2), .exRd(exRd),
        .exReadData1(exReadData1), .exReadData2(exReadData2),
        .exImm(exImm), .exPc(exPc), .stallCycles(stallCycles),
        .bubbleCount(bubbleCount), .flushCount(flushCount)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drv(input logic v, input logic [6:0] c,
                       input logic [1:0] op, input logic [3:0] fn,
                       input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic [63:0] pc);
        idValid   = v;
        {branch, memRead, memToReg, memWrite} = c[6:3];
        {aluSrc, regWrite, regDst} = c[2:0];
        aluOp     = op;
        funct     = fn;
        rs1       = a;
        rs2       = b;
        rd        = d;
        readData1 = 64'h1000 + 64'(a);
        readData2 = 64'h2000 + 64'(b);
        imm       = 64'h30 + 64'(d);
        pcId      = pc;
    endtask

    // c = {branch,memRead,memToReg,memWrite,aluSrc,regWrite,regDst}
    task automatic ld(input logic [4:0] d, input logic [4:0] a,
                      input logic [4:0] b, input logic [63:0] pc);
        drv(1'b1, 7'b0110110, 2'b00, 4'h3, a, b, d, pc);
    endtask

    task automatic sd(input logic [4:0] a, input logic [4:0] b,
                      input logic [63:0] pc);
        drv(1'b1, 7'b0001100, 2'b00, 4'h3, a, b, 5'd0, pc);
    endtask

    task automatic rf(input logic [4:0] d, input logic [4:0] a,
                      input logic [4:0] b, input logic [63:0] pc);
        drv(1'b1, 7'b0000011, 2'b10, 4'h0, a, b, d, pc);
    endtask

    task automatic nop();
        drv(1'b0, 7'b0, 2'b00, 4'h0, 5'd0, 5'd0, 5'd0, 64'h0);
    endtask

    task automatic do_reset();
        nop();
        flush   = 1'b0;
        exStall = 1'b0;
        reset   = 1'b1;
        step();
        step();
        reset   = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        asserts++;
        if ({exValid, exBranch, exMemRead, exMemToReg, exMemWrite,
             exAluSrc, exRegWrite, exRegDst} !== 8'h00) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 0", {exValid, exBranch,
                     exMemRead, exMemToReg, exMemWrite, exAluSrc,
                     exRegWrite, exRegDst});
        end
        asserts++;
        if ({exAluOp, exFunct, exRs1, exRs2, exRd} !== 21'h0 ||
            exReadData1 !== 64'h0 || exPc !== 64'h0 || exImm !== 64'h0 ||
            exReadData2 !== 64'h0) begin
            fails++;
            $display("FAIL reset_data: got rd=%0d pc=%0h want 0",
                     exRd, exPc);
        end
        asserts++;
        if ({stallCycles, bubbleCount, flushCount} !== 96'h0) begin
            fails++;
            $display("FAIL reset_cnt: got %0d/%0d/%0d want 0",
                     stallCycles, bubbleCount, flushCount);
        end
        asserts++;
        if (stallIfId !== 1'b0) begin
            fails++;
            $display("FAIL reset_stall: got %b want 0", stallIfId);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        ld(5'd5, 5'd1, 5'd0, 64'h100);
        step();
        asserts++;
        if (exValid !== 1'b1 || exMemRead !== 1'b1 || exRd !== 5'd5 ||
            exPc !== 64'h100 || exImm !== 64'h35 ||
            exReadData1 !== 64'h1001 || exMemToReg !== 1'b1) begin
            fails++;
            $display("FAIL lu_ld_in_ex: got v=%b rd=%0d pc=%0h want 1/5/100",
                     exValid, exRd, exPc);
        end
        rf(5'd9, 5'd5, 5'd7, 64'h104);
        #1;
        asserts++;
        if (stallIfId !== 1'b1) begin
            fails++;
            $display("FAIL lu_stall: got %b want 1", stallIfId);
        end
        step();
        asserts++;
        if ({exValid, exBranch, exMemRead, exMemToReg, exMemWrite,
             exAluSrc, exRegWrite, exRegDst, exAluOp} !== 10'h0) begin
            fails++;
            $display("FAIL lu_bubble: got v=%b ctrl=%b want 0", exValid,
                     {exMemRead, exRegWrite, exAluOp});
        end
        asserts++;
        if (stallIfId !== 1'b0) begin
            fails++;
            $display("FAIL lu_stall_1cyc: got %b want 0", stallIfId);
        end
        step();
        asserts++;
        if (exValid !== 1'b1 || exRd !== 5'd9 || exRs1 !== 5'd5 ||
            exRs2 !== 5'd7 || exAluOp !== 2'b10 || exRegDst !== 1'b1 ||
            exPc !== 64'h104 || exReadData2 !== 64'h2007) begin
            fails++;
            $display("FAIL lu_r_in_ex: got v=%b rd=%0d pc=%0h want 1/9/104",
                     exValid, exRd, exPc);
        end
        asserts++;
        if (bubbleCount !== (PERF ? 32'd1 : 32'd0) ||
            stallCycles !== (PERF ? 32'd1 : 32'd0)) begin
            fails++;
            $display("FAIL lu_cnt: got b=%0d s=%0d want %0d", bubbleCount,
                     stallCycles, PERF ? 1 : 0);
        end
    endtask

    task automatic test_store_and_x0();
        do_reset();
        ld(5'd5, 5'd1, 5'd0, 64'h200);
        step();
        sd(5'd2, 5'd5, 64'h204);
        #1;
        asserts++;
        if (stallIfId !== 1'b1) begin
            fails++;
            $display("FAIL st_rs2_haz: got %b want 1", stallIfId);
        end
        step();
        asserts++;
        if (exValid !== 1'b0) begin
            fails++;
            $display("FAIL st_bubble: got %b want 0", exValid);
        end
        step();
        asserts++;
        if (exValid !== 1'b1 || exMemWrite !== 1'b1 || exRs2 !== 5'd5 ||
            exRegWrite !== 1'b0) begin
            fails++;
            $display("FAIL st_in_ex: got v=%b mw=%b rs2=%0d want 1/1/5",
                     exValid, exMemWrite, exRs2);
        end
        ld(5'd0, 5'd3, 5'd0, 64'h208);
        step();
        rf(5'd4, 5'd0, 5'd0, 64'h20c);
        #1;
        asserts++;
        if (stallIfId !== 1'b0 || exMemRead !== 1'b1) begin
            fails++;
            $display("FAIL x0_nohaz: got stall=%b mr=%b want 0/1",
                     stallIfId, exMemRead);
        end
    endtask

    task automatic test_rs2_unused();
        do_reset();
        ld(5'd5, 5'd1, 5'd0, 64'h300);
        step();
        ld(5'd7, 5'd6, 5'd5, 64'h304);
        #1;
        asserts++;
        if (stallIfId !== 1'b0) begin
            fails++;
            $display("FAIL rs2_unused: got %b want 0", stallIfId);
        end
        step();
        asserts++;
        if (exValid !== 1'b1 || exRd !== 5'd7 || exPc !== 64'h304) begin
            fails++;
            $display("FAIL rs2_unused_ld: got v=%b rd=%0d want 1/7",
                     exValid, exRd);
        end
    endtask

    task automatic test_flush();
        do_reset();
        ld(5'd5, 5'd1, 5'd0, 64'h400);
        step();
        rf(5'd9, 5'd5, 5'd7, 64'h404);
        flush = 1'b1;
        #1;
        asserts++;
        if (stallIfId !== 1'b0) begin
            fails++;
            $display("FAIL fl_stall: got %b want 0", stallIfId);
        end
        step();
        flush = 1'b0;
        nop();
        asserts++;
        if (exValid !== 1'b0 || exMemRead !== 1'b0 || exRd !== 5'd0) begin
            fails++;
            $display("FAIL fl_bubble: got v=%b rd=%0d want 0/0",
                     exValid, exRd);
        end
        asserts++;
        if (flushCount !== (PERF ? 32'd1 : 32'd0) ||
            bubbleCount !== 32'd0 || stallCycles !== 32'd0) begin
            fails++;
            $display("FAIL fl_cnt: got f=%0d b=%0d s=%0d want %0d/0/0",
                     flushCount, bubbleCount, stallCycles, PERF ? 1 : 0);
        end
    endtask

    task automatic test_ex_stall();
        do_reset();
        rf(5'd9, 5'd1, 5'd2, 64'h500);
        step();
        rf(5'd10, 5'd3, 5'd4, 64'h504);
        exStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            asserts++;
            if (stallIfId !== 1'b1) begin
                fails++;
                $display("FAIL hold_stall[%0d]: got %b want 1", i, stallIfId);
            end
            step();
            asserts++;
            if (exValid !== 1'b1 || exRd !== 5'd9 || exPc !== 64'h500 ||
                exReadData1 !== 64'h1001 || exRegWrite !== 1'b1) begin
                fails++;
                $display("FAIL hold_regs[%0d]: got rd=%0d pc=%0h want 9/500",
                         i, exRd, exPc);
            end
        end
        exStall = 1'b0;
        #1;
        asserts++;
        if (stallIfId !== 1'b0 ||
            stallCycles !== (PERF ? 32'd3 : 32'd0)) begin
            fails++;
            $display("FAIL hold_release: got stall=%b cyc=%0d want 0/%0d",
                     stallIfId, stallCycles, PERF ? 3 : 0);
        end
        step();
        asserts++;
        if (exValid !== 1'b1 || exRd !== 5'd10 || exPc !== 64'h504) begin
            fails++;
            $display("FAIL hold_next: got rd=%0d pc=%0h want 10/504",
                     exRd, exPc);
        end
    endtask

    task automatic test_stall_vs_hazard();
        do_reset();
        ld(5'd5, 5'd1, 5'd0, 64'h600);
        step();
        rf(5'd9, 5'd5, 5'd7, 64'h604);
        exStall = 1'b1;
        step();
        asserts++;
        if (exValid !== 1'b1 || exRd !== 5'd5 || exMemRead !== 1'b1 ||
            bubbleCount !== 32'd0) begin
            fails++;
            $display("FAIL sh_hold: got v=%b rd=%0d b=%0d want 1/5/0",
                     exValid, exRd, bubbleCount);
        end
        exStall = 1'b0;
        #1;
        asserts++;
        if (stallIfId !== 1'b1) begin
            fails++;
            $display("FAIL sh_rehaz: got %b want 1", stallIfId);
        end
        step();
        asserts++;
        if (exValid !== 1'b0 || bubbleCount !== (PERF ? 32'd1 : 32'd0)) begin
            fails++;
            $display("FAIL sh_bubble: got v=%b b=%0d want 0/%0d",
                     exValid, bubbleCount, PERF ? 1 : 0);
        end
        step();
        asserts++;
        if (exValid !== 1'b1 || exRd !== 5'd9) begin
            fails++;
            $display("FAIL sh_load: got v=%b rd=%0d want 1/9", exValid, exRd);
        end
    endtask

    task automatic test_sanitize();
        do_reset();
        drv(1'b1, 7'b0011101, 2'b00, 4'h3, 5'd2, 5'd6, 5'd0, 64'h700);
        step();
        asserts++;
        if (exMemToReg !== 1'b0 || exRegDst !== 1'b0 ||
            exMemWrite !== 1'b1 || exAluSrc !== 1'b1) begin
            fails++;
            $display("FAIL sanitize: got m2r=%b rdst=%b mw=%b want 0/0/1",
                     exMemToReg, exRegDst, exMemWrite);
        end
        drv(1'b0, 7'b1111111, 2'b11, 4'hf, 5'd3, 5'd4, 5'd8, 64'h704);
        step();
        asserts++;
        if ({exValid, exBranch, exMemRead, exMemWrite, exRegWrite,
             exAluOp, exFunct} !== 11'h0 || exPc !== 64'h704 ||
            exRd !== 5'd8) begin
            fails++;
            $display("FAIL invalid_ld: got v=%b op=%b pc=%0h want 0/0/704",
                     exValid, exAluOp, exPc);
        end
        asserts++;
        if (stallCycles !== 32'd0 || bubbleCount !== 32'd0 ||
            flushCount !== 32'd0) begin
            fails++;
            $display("FAIL idle_cnt: got %0d/%0d/%0d want 0",
                     stallCycles, bubbleCount, flushCount);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        ld(5'd5, 5'd1, 5'd0, 64'h800);
        step();
        rf(5'd9, 5'd5, 5'd7, 64'h804);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        asserts++;
        if (exValid !== 1'b0 || exRd !== 5'd0 || exMemRead !== 1'b0 ||
            stallIfId !== 1'b0 || stallCycles !== 32'd0) begin
            fails++;
            $display("FAIL rst_mid: got v=%b rd=%0d st=%b want 0/0/0",
                     exValid, exRd, stallIfId);
        end
        step();
        asserts++;
        if (exValid !== 1'b1 || exRd !== 5'd9 || exPc !== 64'h804) begin
            fails++;
            $display("FAIL rst_keep: got v=%b rd=%0d want 1/9",
                     exValid, exRd);
        end
    endtask

    initial begin
        reset   = 1'b1;
        flush   = 1'b0;
        exStall = 1'b0;
        nop();
        test_reset();
        test_load_use();
        test_store_and_x0();
        test_rs2_unused();
        test_flush();
        test_ex_stall();
        test_stall_vs_hazard();
        test_sanitize();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
